cr16_bram_loader: RTL and testbench

// Boot-time program loader: receives a framed byte stream over a valid/ready handshake and writes it
// as 16-bit words into BRAM port B, the port cr16_top otherwise only reads for display.

---
 rtl/cr16_bram_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_cr16_bram_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_bram_loader.sv
// ---------------------------------------------------------------------------
// cr16_bram_loader
//
// Boot-time program loader. Accepts a framed byte stream on a valid/ready
// handshake, assembles it into 16-bit words and writes them into BRAM port B.
// The CR16 core is held in reset until the whole image has been written and
// its checksum verified.
//
// Frame: LEN_HI, LEN_LO (word count N, big-endian), N words (high byte first),
//        one checksum byte = XOR of all 2N data bytes (0x00 when N = 0).
//
// Ports
//   I_CLK                 clock
//   I_NRESET              asynchronous active-low reset
//   I_BYTE_VALID          source presents a byte on I_BYTE
//   I_BYTE[7:0]           stream byte
//   O_BYTE_READY          loader accepts I_BYTE this cycle
//   O_MEM_ADDRESS_B       BRAM port B word address
//   O_MEM_DATA_B[15:0]    BRAM port B write data
//   O_MEM_WRITE_ENABLE_B  BRAM port B write strobe (one cycle per word)
//   O_CPU_NRESET          active-low CR16 reset, released once load verified
//   O_DONE                image written and checksum matched
//   O_ERROR               length, checksum or timeout failure
//   O_WORD_COUNT[15:0]    words written so far in the current frame
// ---------------------------------------------------------------------------
module cr16_bram_loader #(
    parameter int P_ADDRESS_WIDTH  = 10,
    parameter int P_START_ADDRESS  = 0,
    parameter int P_TIMEOUT_CYCLES = 0
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic                       I_BYTE_VALID,
    input  logic [7:0]                 I_BYTE,
    output logic                       O_BYTE_READY,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS_B,
    output logic [15:0]                O_MEM_DATA_B,
    output logic                       O_MEM_WRITE_ENABLE_B,
    output logic                       O_CPU_NRESET,
    output logic                       O_DONE,
    output logic                       O_ERROR,
    output logic [15:0]                O_WORD_COUNT
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // Words that fit between the start address and the top of the BRAM.
    localparam logic [31:0] L_CAPACITY =
        32'((2 ** P_ADDRESS_WIDTH) - P_START_ADDRESS);
    localparam logic [P_ADDRESS_WIDTH-1:0] L_START =
        P_ADDRESS_WIDTH'(P_START_ADDRESS);
    localparam bit L_TIMEOUT_EN = (P_TIMEOUT_CYCLES != 0);
    // Timeout fires on the edge where the idle count would reach the limit.
    localparam logic [31:0] L_IDLE_LIMIT =
        (P_TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(P_TIMEOUT_CYCLES - 1);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [15:0]                  r_len;
    logic [7:0]                   r_hi;
    logic [7:0]                   r_csum;
    logic [15:0]                  r_word_count;
    logic [31:0]                  r_idle;
    logic [P_ADDRESS_WIDTH-1:0]   r_addr;
    logic [15:0]                  r_data;

    logic                         w_accept;
    logic [15:0]                  w_len;
    logic                         w_len_oversize;
    logic                         w_last_word;
    logic                         w_counting;
    logic                         w_timeout;
    logic [P_ADDRESS_WIDTH-1:0]   w_word_addr;

    assign w_accept       = I_BYTE_VALID && O_BYTE_READY;
    assign w_len          = {r_len[15:8], I_BYTE};
    assign w_len_oversize = ({16'd0, w_len} > L_CAPACITY);
    // Evaluated in S_WRITE, before the word count has been bumped.
    assign w_last_word    = ((r_word_count + 16'd1) == r_len);
    // Length check bounds the index below capacity, so truncation never wraps.
    assign w_word_addr    = L_START + P_ADDRESS_WIDTH'(r_word_count);

    // Idle cycles only count once a frame has started and until it resolves.
    always_comb begin
        case (r_state)
            S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK: w_counting = 1'b1;
            default:                                          w_counting = 1'b0;
        endcase
    end

    assign w_timeout = L_TIMEOUT_EN && w_counting && !w_accept &&
                       (r_idle == L_IDLE_LIMIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_state <= S_LEN_HI;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this block free of latches
    // whichever case arm is taken.
    always_comb begin
        w_next_state = r_state;
        if (w_timeout) begin
            w_next_state = S_ERROR;
        end else begin
            case (r_state)
                S_LEN_HI: if (w_accept) w_next_state = S_LEN_LO;
                S_LEN_LO: begin
                    if (w_accept) begin
                        if (w_len_oversize)      w_next_state = S_ERROR;
                        else if (w_len == 16'd0) w_next_state = S_CHECK;
                        else                     w_next_state = S_DATA_HI;
                    end
                end
                S_DATA_HI: if (w_accept) w_next_state = S_DATA_LO;
                S_DATA_LO: if (w_accept) w_next_state = S_WRITE;
                S_WRITE:   w_next_state = w_last_word ? S_CHECK : S_DATA_HI;
                S_CHECK: begin
                    if (w_accept) begin
                        w_next_state = (I_BYTE == r_csum) ? S_DONE : S_ERROR;
                    end
                end
                S_DONE:  w_next_state = S_DONE;
                S_ERROR: w_next_state = S_ERROR;
                default: w_next_state = S_ERROR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (all driven from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        O_BYTE_READY         = 1'b0;
        O_MEM_WRITE_ENABLE_B = 1'b0;
        O_DONE               = 1'b0;
        O_ERROR              = 1'b0;
        O_CPU_NRESET         = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK:
                O_BYTE_READY = 1'b1;
            S_WRITE:
                O_MEM_WRITE_ENABLE_B = 1'b1;
            S_DONE: begin
                O_DONE       = 1'b1;
                O_CPU_NRESET = 1'b1;
            end
            S_ERROR:
                O_ERROR = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length, word assembly, checksum, write port, idle counter
    // ------------------------------------------------------------------
    // NOTE: only the loader's own registers are reset; the BRAM contents
    // are deliberately left alone so a reset never erases written words.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_len        <= 16'd0;
            r_hi         <= 8'd0;
            r_csum       <= 8'd0;
            r_word_count <= 16'd0;
            r_idle       <= 32'd0;
            r_addr       <= '0;
            r_data       <= 16'd0;
        end else begin
            if (!w_counting || w_accept) begin
                r_idle <= 32'd0;
            end else if (L_TIMEOUT_EN) begin
                r_idle <= r_idle + 32'd1;
            end

            if (w_accept) begin
                case (r_state)
                    S_LEN_HI:  r_len[15:8] <= I_BYTE;
                    S_LEN_LO:  r_len[7:0]  <= I_BYTE;
                    S_DATA_HI: begin
                        r_hi   <= I_BYTE;
                        r_csum <= r_csum ^ I_BYTE;
                    end
                    S_DATA_LO: begin
                        // Address and data are latched here so they are
                        // stable for the whole S_WRITE cycle and hold after.
                        r_csum <= r_csum ^ I_BYTE;
                        r_data <= {r_hi, I_BYTE};
                        r_addr <= w_word_addr;
                    end
                    default: ;
                endcase
            end

            if (r_state == S_WRITE) begin
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

    assign O_MEM_ADDRESS_B = r_addr;
    assign O_MEM_DATA_B    = r_data;
    assign O_WORD_COUNT    = r_word_count;

endmodule

// File: tb/tb_cr16_bram_loader.sv
// ---------------------------------------------------------------------------
// tb_cr16_bram_loader
//
// Directed bench for cr16_bram_loader (10-bit address, start 0, timeout 8).
// A negedge monitor records every BRAM write and flags write strobes that
// last more than one cycle or coincide with READY.
// ---------------------------------------------------------------------------
module tb_cr16_bram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_nreset;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          ready_viol = 0;
    int          pulse_viol = 0;
    logic        prev_we    = 1'b0;

    cr16_bram_loader #(
        .P_ADDRESS_WIDTH  (10),
        .P_START_ADDRESS  (0),
        .P_TIMEOUT_CYCLES (8)
    ) dut (
        .I_CLK                (clk),
        .I_NRESET             (rst_n),
        .I_BYTE_VALID         (byte_valid),
        .I_BYTE               (byte_in),
        .O_BYTE_READY         (byte_ready),
        .O_MEM_ADDRESS_B      (mem_addr),
        .O_MEM_DATA_B         (mem_data),
        .O_MEM_WRITE_ENABLE_B (mem_we),
        .O_CPU_NRESET         (cpu_nreset),
        .O_DONE               (done),
        .O_ERROR              (error),
        .O_WORD_COUNT         (word_count)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
            if (byte_ready) ready_viol <= ready_viol + 1;
            if (prev_we)    pulse_viol <= pulse_viol + 1;
        end
        prev_we <= rst_n && mem_we;
    end

    task automatic apply_reset();
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        @(posedge clk);
        #1;
    endtask

    // Present one byte after 'gap' idle cycles; ok=1 once it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        logic rdy;
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
        bit ok;
        int gap;
        for (int i = 0; i < bytes.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            send_byte(bytes[i], gap, ok);
            if (!ok) begin
                n_checks++;
                $display("FAIL accept_byte%0d: byte %h not accepted within 40 cycles", i, bytes[i]);
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++; if (byte_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", byte_ready); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b exp 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 10'd0) $display("FAIL rst_addr: got %h exp 000", mem_addr); else n_pass++;
        n_checks++; if (mem_data !== 16'd0) $display("FAIL rst_data: got %h exp 0000", mem_data); else n_pass++;
        n_checks++; if (cpu_nreset !== 1'b0) $display("FAIL rst_cpu_nreset: got %b exp 0", cpu_nreset); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL rst_error: got %b exp 0", error); else n_pass++;
        n_checks++; if (word_count !== 16'd0) $display("FAIL rst_word_count: got %0d exp 0", word_count); else n_pass++;
        apply_reset();
    endtask

    // 12^34^AB^CD = 40, the correct checksum for this image.
    task automatic test_load(input string tag, input int max_gap);
        apply_reset();
        send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, max_gap);
        n_checks++;
        if (wr_data.size() != 2) begin
            $display("FAIL %s_write_count: got %0d exp 2", tag, wr_data.size());
        end else begin
            n_pass++;
            n_checks++; if ({wr_addr[0], wr_data[0]} !== {10'd0, 16'h1234})
                $display("FAIL %s_write0: got %h@%0d exp 1234@0", tag, wr_data[0], wr_addr[0]); else n_pass++;
            n_checks++; if ({wr_addr[1], wr_data[1]} !== {10'd1, 16'hABCD})
                $display("FAIL %s_write1: got %h@%0d exp abcd@1", tag, wr_data[1], wr_addr[1]); else n_pass++;
        end
        n_checks++; if ({done, cpu_nreset, error} !== 3'b110)
            $display("FAIL %s_status: got done/cpu/err=%b exp 110", tag, {done, cpu_nreset, error}); else n_pass++;
        n_checks++; if (word_count !== 16'd2) $display("FAIL %s_word_count: got %0d exp 2", tag, word_count); else n_pass++;
        n_checks++; if (byte_ready !== 1'b0) $display("FAIL %s_done_ready: got %b exp 0", tag, byte_ready); else n_pass++;
        n_checks++; if (pulse_viol !== 0) $display("FAIL %s_we_pulse: got %0d long pulses exp 0", tag, pulse_viol); else n_pass++;
        n_checks++; if (ready_viol !== 0) $display("FAIL %s_ready_in_write: got %0d exp 0", tag, ready_viol); else n_pass++;
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        send_frame('{8'h00, 8'h01, 8'h12, 8'h34, 8'h00}, 0);
        n_checks++; if (wr_data.size() != 1 || wr_data[0] !== 16'h1234 || wr_addr[0] !== 10'd0)
            $display("FAIL badsum_write: got %0d writes exp one 1234@0", wr_data.size()); else n_pass++;
        n_checks++; if ({done, cpu_nreset, error} !== 3'b001)
            $display("FAIL badsum_status: got done/cpu/err=%b exp 001", {done, cpu_nreset, error}); else n_pass++;
    endtask

    task automatic test_length();
        // N = 1025 exceeds the 1024-word BRAM: error on the LEN_LO edge.
        apply_reset();
        send_frame('{8'h04, 8'h01}, 0);
        n_checks++; if (error !== 1'b1) $display("FAIL len_over_error: got %b exp 1", error); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wr_data.size() != 0) $display("FAIL len_over_writes: got %0d exp 0", wr_data.size()); else n_pass++;
        n_checks++; if (cpu_nreset !== 1'b0) $display("FAIL len_over_cpu: got %b exp 0", cpu_nreset); else n_pass++;
        // N = 1024 fills the BRAM exactly and must be accepted.
        apply_reset();
        send_frame('{8'h04, 8'h00}, 0);
        n_checks++; if ({error, byte_ready} !== 2'b01)
            $display("FAIL len_max_ok: got err/ready=%b exp 01", {error, byte_ready}); else n_pass++;
    endtask

    task automatic test_zero_len();
        apply_reset();
        send_frame('{8'h00, 8'h00, 8'h00}, 0);
        n_checks++; if ({done, cpu_nreset, error} !== 3'b110)
            $display("FAIL zero_status: got done/cpu/err=%b exp 110", {done, cpu_nreset, error}); else n_pass++;
        n_checks++; if (wr_data.size() != 0 || word_count !== 16'd0)
            $display("FAIL zero_writes: got %0d writes wc=%0d exp 0/0", wr_data.size(), word_count); else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        send_frame('{8'h00, 8'h01, 8'h12}, 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 7) begin
                n_checks++; if (error !== 1'b0) $display("FAIL timeout_early: got %b exp 0 at cycle 7", error); else n_pass++;
            end
        end
        n_checks++; if (error !== 1'b1) $display("FAIL timeout_fire: got %b exp 1 at cycle 8", error); else n_pass++;
        n_checks++; if (wr_data.size() != 0) $display("FAIL timeout_writes: got %0d exp 0", wr_data.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB}, 0);
        n_checks++; if (word_count !== 16'd1) $display("FAIL mid_word_count: got %0d exp 1", word_count); else n_pass++;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({byte_ready, mem_we, mem_addr, mem_data, cpu_nreset, done, error, word_count} !==
            {1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0})
            $display("FAIL mid_reset_values: got rdy=%b we=%b a=%h d=%h cpu=%b dn=%b er=%b wc=%0d exp 1 0 000 0000 0 0 0 0",
                     byte_ready, mem_we, mem_addr, mem_data, cpu_nreset, done, error, word_count);
        else n_pass++;
        test_load("restart", 0);
    endtask

    initial begin
        test_reset();
        test_load("held", 0);
        test_load("gaps", 4);
        test_bad_checksum();
        test_length();
        test_zero_len();
        test_timeout();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

endmodule
